// File: rtl/if_id_hazard_unit.sv
// IF/ID pipeline register with load-use stall and taken-branch flush control.
// Latency: a valid fetch reaches outPc/outInstr one edge after it is presented.
// Backpressure: pcWrite drops (and IF/ID holds) while a load-use stall is active.
module if_id_hazard_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  inPc,
  input  logic [31:0] inInstr,
  input  logic        inValid,
  input  logic        exMemRead,
  input  logic [4:0]  exRd,
  input  logic        branchTaken,
  output logic [7:0]  outPc,
  output logic [31:0] outInstr,
  output logic        outValid,
  output logic        pcWrite,
  output logic        outBubble,
  output logic [15:0] stallCount
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  typedef enum logic [1:0] {LD_NORMAL, LD_HOLD, LD_BUBBLE} load_t;

  // Remaining-cycle preload values; unused when the matching parameter is 1.
  localparam logic [3:0] STALL_INIT = (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  load_t      load_sel;
  logic       stall_inc;
  logic       hazard;

  // Load-use hazard: instruction in decode reads the register a load in EX is writing.
  always_comb begin
    hazard = outValid & exMemRead & (exRd != 5'd0) &
             ((exRd == outInstr[25:21]) | (exRd == outInstr[20:16]));
  end

  // Next-state and control decode; branch beats any stall, which beats normal flow.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pcWrite   = 1'b1;
    outBubble = 1'b0;
    load_sel  = LD_NORMAL;
    stall_inc = 1'b0;
    if (branchTaken) begin
      outBubble = 1'b1;
      load_sel  = LD_BUBBLE;
      state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_nxt   = FLUSH_INIT;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            pcWrite   = 1'b0;
            outBubble = 1'b1;
            load_sel  = LD_HOLD;
            stall_inc = 1'b1;
            // With a single stall cycle the bubble now in ID/EX clears the hazard.
            if (STALL_CYCLES > 1) begin
              state_nxt = STALL;
              cnt_nxt   = STALL_INIT;
            end
          end
        end
        STALL: begin
          pcWrite   = 1'b0;
          outBubble = 1'b1;
          load_sel  = LD_HOLD;
          stall_inc = 1'b1;
          if (cnt == 4'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 4'd1;
        end
        FLUSH: begin
          load_sel = LD_BUBBLE;
          if (cnt == 4'd0) state_nxt = RUN;
          else             cnt_nxt   = cnt - 4'd1;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // FSM state and remaining-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // IF/ID register: load fetch, hold during stall, or load a bubble on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      outPc    <= 8'h00;
      outInstr <= 32'h0;
      outValid <= 1'b0;
    end else begin
      case (load_sel)
        LD_NORMAL: begin
          outPc    <= inPc;
          outInstr <= inValid ? inInstr : 32'h0;
          outValid <= inValid;
        end
        LD_BUBBLE: begin
          outPc    <= inPc;
          outInstr <= 32'h0;
          outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Saturating bring-up counter of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)
      stallCount <= 16'h0;
    else if (stall_inc && (stallCount != 16'hFFFF))
      stallCount <= stallCount + 16'd1;
  end

endmodule
